clock_counter: RTL and testbench

Free-running BCD minutes:seconds timekeeper for the alarm clock. It divides the system clock down to a one-second tick and advances a four-digit MM:SS count from 00:00 to 59:59, then wraps to 00:00. It accepts a minutes preset from the user-entry path. Its digit outputs feed the running-time inputs of the display selection stage; that stage shows the preset digits directly while `load` is high.

---
 rtl/clock_counter.sv | 114 +++++++++++
 tb/tb_clock_counter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_counter.sv
// BCD MM:SS timekeeper for the alarm clock.
// Divides clk to a one-second tick; minutes are preset through load.
module clock_counter #(
  parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  input  logic       load,
  input  logic [3:0] load_minutes_ones,
  input  logic [2:0] load_minutes_tens,
  output logic [3:0] seconds_ones,
  output logic [2:0] seconds_tens,
  output logic [3:0] minutes_ones,
  output logic [2:0] minutes_tens,
  output logic       sec_pulse,
  output logic       hour_pulse
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [2:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [2:0]    min_tens_q, min_tens_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          hour_pulse_q, hour_pulse_d;

  logic tick;
  logic so_wrap;
  logic st_wrap;
  logic mo_wrap;
  logic mt_wrap;

  assign so_wrap = (sec_ones_q == 4'd9);
  assign st_wrap = so_wrap && (sec_tens_q == 3'd5);
  assign mo_wrap = st_wrap && (min_ones_q == 4'd9);
  assign mt_wrap = mo_wrap && (min_tens_q == 3'd5);

  // Prescaler: holds (not cleared) while run is low.
  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (load) begin
      presc_d = '0;
    end else if (run) begin
      if (presc_q == TERM) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_comb begin
    sec_ones_d   = sec_ones_q;
    sec_tens_d   = sec_tens_q;
    min_ones_d   = min_ones_q;
    min_tens_d   = min_tens_q;
    sec_pulse_d  = 1'b0;
    hour_pulse_d = 1'b0;
    if (load) begin
      // Clamp so illegal presets never reach the display.
      min_ones_d = (load_minutes_ones > 4'd9) ? 4'd9 : load_minutes_ones;
      min_tens_d = (load_minutes_tens > 3'd5) ? 3'd5 : load_minutes_tens;
      sec_ones_d = '0;
      sec_tens_d = '0;
    end else if (tick) begin
      sec_pulse_d  = 1'b1;
      hour_pulse_d = mt_wrap;
      sec_ones_d   = so_wrap ? 4'd0 : sec_ones_q + 4'd1;
      if (so_wrap) begin
        sec_tens_d = st_wrap ? 3'd0 : sec_tens_q + 3'd1;
      end
      if (st_wrap) begin
        min_ones_d = mo_wrap ? 4'd0 : min_ones_q + 4'd1;
      end
      if (mo_wrap) begin
        min_tens_d = mt_wrap ? 3'd0 : min_tens_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q      <= '0;
      sec_ones_q   <= '0;
      sec_tens_q   <= '0;
      min_ones_q   <= '0;
      min_tens_q   <= '0;
      sec_pulse_q  <= 1'b0;
      hour_pulse_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      sec_ones_q   <= sec_ones_d;
      sec_tens_q   <= sec_tens_d;
      min_ones_q   <= min_ones_d;
      min_tens_q   <= min_tens_d;
      sec_pulse_q  <= sec_pulse_d;
      hour_pulse_q <= hour_pulse_d;
    end
  end

  assign seconds_ones = sec_ones_q;
  assign seconds_tens = sec_tens_q;
  assign minutes_ones = min_ones_q;
  assign minutes_tens = min_tens_q;
  assign sec_pulse    = sec_pulse_q;
  assign hour_pulse   = hour_pulse_q;

endmodule

// File: tb/tb_clock_counter.sv
// Scoreboard bench for clock_counter against a seconds-count model.
// Directed plan scenarios followed by randomized traffic.
module tb_clock_counter;

  localparam int T = 4;

  typedef struct packed {
    logic [3:0] so;
    logic [2:0] st;
    logic [3:0] mo;
    logic [2:0] mt;
    logic       sp;
    logic       hp;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       load;
  logic [3:0] lmo;
  logic [2:0] lmt;
  logic [3:0] seconds_ones;
  logic [2:0] seconds_tens;
  logic [3:0] minutes_ones;
  logic [2:0] minutes_tens;
  logic       sec_pulse;
  logic       hour_pulse;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int hour_cnt = 0;

  obs_t exp_q[$];

  // Reference state: elapsed seconds within the hour plus prescaler phase
  int secs = 0;
  int phase = 0;
  bit m_sp = 0;
  bit m_hp = 0;

  clock_counter #(.TICKS_PER_SEC(T)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .run               (run),
    .load              (load),
    .load_minutes_ones (lmo),
    .load_minutes_tens (lmt),
    .seconds_ones      (seconds_ones),
    .seconds_tens      (seconds_tens),
    .minutes_ones      (minutes_ones),
    .minutes_tens      (minutes_tens),
    .sec_pulse         (sec_pulse),
    .hour_pulse        (hour_pulse)
  );

  always #5 clk = ~clk;

  function automatic obs_t expected();
    obs_t e;
    e.so = 4'(secs % 10);
    e.st = 3'((secs / 10) % 6);
    e.mo = 4'((secs / 60) % 10);
    e.mt = 3'(secs / 600);
    e.sp = m_sp;
    e.hp = m_hp;
    return e;
  endfunction

  task automatic step(input bit r_n, input bit rn, input bit ld,
                      input int mo, input int mt);
    int cm;
    int ct;
    @(negedge clk);
    reset_n = r_n;
    run     = rn;
    load    = ld;
    lmo     = 4'(mo);
    lmt     = 3'(mt);
    m_sp = 0;
    m_hp = 0;
    if (!r_n) begin
      secs  = 0;
      phase = 0;
    end else if (ld) begin
      cm = (mo > 9) ? 9 : mo;
      ct = (mt > 5) ? 5 : mt;
      secs  = (ct * 10 + cm) * 60;
      phase = 0;
    end else if (rn) begin
      if (phase == T - 1) begin
        phase = 0;
        secs  = (secs + 1) % 3600;
        m_sp  = 1;
        m_hp  = (secs == 0);
      end else begin
        phase++;
      end
    end
    exp_q.push_back(expected());
  endtask

  task automatic cycles(input int n, input bit rn);
    for (int i = 0; i < n; i++) step(1, rn, 0, 0, 0);
  endtask

  task automatic preset(input int mo, input int mt, input int n);
    for (int i = 0; i < n; i++) step(1, 1, 1, mo, mt);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a new registered output
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {seconds_ones, seconds_tens, minutes_ones, minutes_tens,
             sec_pulse, hour_pulse};
        pulse_cnt += int'(sec_pulse);
        hour_cnt  += int'(hour_pulse);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle t=%0t: got %0d%0d:%0d%0d sp=%b hp=%b, expected %0d%0d:%0d%0d sp=%b hp=%b",
                   $time, a.mt, a.mo, a.st, a.so, a.sp, a.hp,
                   e.mt, e.mo, e.st, e.so, e.sp, e.hp);
        end
      end
    end
  end

  initial begin
    int w;
    int mo;
    int mt;
    reset_n = 0;
    run     = 0;
    load    = 0;
    lmo     = '0;
    lmt     = '0;

    // Reset then 40 running cycles -> 00:10, ten pulses
    step(0, 1, 0, 0, 0);
    settle();
    chk("reset_digits", {minutes_tens, minutes_ones, seconds_tens, seconds_ones}, 0);
    pulse_cnt = 0;
    cycles(40, 1);
    settle();
    chk("s1_sec_ones", seconds_ones, 0);
    chk("s1_sec_tens", seconds_tens, 1);
    chk("s1_pulses", pulse_cnt, 10);

    // Preset 12 held three cycles
    preset(2, 1, 3);
    settle();
    chk("s2_min_ones", minutes_ones, 2);
    chk("s2_min_tens", minutes_tens, 1);
    cycles(8, 1);

    // 59:00 through the hour wrap
    preset(9, 5, 1);
    hour_cnt = 0;
    cycles(244, 1);
    settle();
    chk("s3_hour_pulses", hour_cnt, 1);
    chk("s3_min_wrap", minutes_tens * 10 + minutes_ones, 0);

    // Illegal preset clamps to 59:00
    preset(12, 7, 1);
    settle();
    chk("s4_clamp_mo", minutes_ones, 9);
    chk("s4_clamp_mt", minutes_tens, 5);
    cycles(4, 1);

    // 03:27, drop run on the terminal-count cycle
    preset(3, 0, 1);
    cycles(27 * T + T - 1, 1);
    cycles(10, 0);
    settle();
    chk("s5_frozen", seconds_tens * 10 + seconds_ones, 27);
    cycles(1, 1);
    settle();
    chk("s5_resume", seconds_tens * 10 + seconds_ones, 28);

    // Load on the 07:59 tick cycle, then reset mid-count
    preset(7, 0, 1);
    cycles(59 * T + T - 1, 1);
    step(1, 1, 1, 5, 0);
    settle();
    chk("s6_load_wins", minutes_ones, 5);
    chk("s6_no_pulse", sec_pulse, 0);
    cycles(6, 1);
    step(0, 1, 1, 9, 3);
    settle();
    chk("s6_reset", {minutes_tens, minutes_ones, seconds_tens, seconds_ones}, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      mo = $urandom_range(15, 0);
      mt = $urandom_range(7, 0);
      step(($urandom_range(299, 0) != 0),
           ($urandom_range(5, 0) != 0),
           ($urandom_range(39, 0) == 0), mo, mt);
    end

    w = 0;
    while (exp_q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
